// File: rtl/axi_lite_ram_slave_pkg.sv
// Shared types and helpers for the AXI4-Lite RAM responder.
package axi_lite_ram_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {WIdle, WExec, WResp} w_state_e;
  typedef enum logic [1:0] {RIdle, RExec, RWait, RData} r_state_e;

  // Wrapped offset compare covers addr < base without a separate test.
  function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] base,
                                         input int unsigned depth_log2);
    logic [32:0] off;
    off = {1'b0, addr - base};
    return off < (33'd1 << (depth_log2 + 2));
  endfunction

endpackage

// File: rtl/axi_lite_ram_slave_bram_bytewise.sv
// Single-port byte-writable word RAM, registered read data (1-cycle latency).
module axi_lite_ram_slave_bram_bytewise #(
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           din,
  output logic [31:0]           dout
);

  logic [31:0] mem [2**DEPTH_LOG2];

  // No-change mode: dout only updates on read accesses.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
      end
      if (we == 4'b0000) dout <= mem[addr];
    end
  end

endmodule

// File: rtl/axi_lite_ram_slave.sv
// AXI4-Lite responder over a shared single-port RAM; independent read/write FSMs.
module axi_lite_ram_slave
  import axi_lite_ram_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] axi_araddr,
  input  logic        axi_arvalid,
  input  logic [2:0]  axi_arprot,
  output logic        axi_arready,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  input  logic [31:0] axi_awaddr,
  input  logic        axi_awvalid,
  input  logic [2:0]  axi_awprot,
  output logic        axi_awready,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  output logic [1:0]  axi_bresp,
  output logic        axi_bvalid,
  input  logic        axi_bready
);

  logic unused_prot;
  assign unused_prot = ^{axi_arprot, axi_awprot};

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic                  aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic                  awready_q, awready_d, wready_q, wready_d;
  logic [DEPTH_LOG2-1:0] waddr_q, waddr_d;
  logic                  wok_q, wok_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;

  logic                  arready_q, arready_d;
  logic [DEPTH_LOG2-1:0] raddr_q, raddr_d;
  logic                  rok_q, rok_d;
  logic                  rvalid_q, rvalid_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic                  aw_hs, w_hs, ar_hs, w_exec;
  logic [DEPTH_LOG2-1:0] aw_idx, ar_idx;
  logic                  ram_en;
  logic [3:0]            ram_we;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [31:0]           ram_dout;

  assign aw_hs  = axi_awvalid & awready_q;
  assign w_hs   = axi_wvalid & wready_q;
  assign ar_hs  = axi_arvalid & arready_q;
  assign aw_idx = DEPTH_LOG2'((axi_awaddr - BASE_ADDR) >> 2);
  assign ar_idx = DEPTH_LOG2'((axi_araddr - BASE_ADDR) >> 2);
  assign w_exec = (w_state_q == WExec);

  always_comb begin
    w_state_d = w_state_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    waddr_d   = waddr_q;
    wok_d     = wok_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    unique case (w_state_q)
      WIdle: begin
        if (aw_hs) begin
          aw_got_d = 1'b1;
          waddr_d  = aw_idx;
          wok_d    = addr_in_range(axi_awaddr, BASE_ADDR, DEPTH_LOG2);
        end
        if (w_hs) begin
          w_got_d = 1'b1;
          wdata_d = axi_wdata;
          wstrb_d = axi_wstrb;
        end
        if (aw_got_d && w_got_d) begin
          w_state_d = WExec;
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
        end
      end
      WExec: begin
        bvalid_d  = 1'b1;
        bresp_d   = wok_q ? RESP_OKAY : RESP_DECERR;
        w_state_d = WResp;
      end
      WResp: begin
        if (axi_bready) begin
          bvalid_d  = 1'b0;
          w_state_d = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
    awready_d = (w_state_d == WIdle) && !aw_got_d;
    wready_d  = (w_state_d == WIdle) && !w_got_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    raddr_d   = raddr_q;
    rok_d     = rok_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      RIdle: begin
        if (ar_hs) begin
          raddr_d   = ar_idx;
          rok_d     = addr_in_range(axi_araddr, BASE_ADDR, DEPTH_LOG2);
          r_state_d = RExec;
        end
      end
      // The RAM port belongs to the write FSM while it executes.
      RExec: if (!w_exec) r_state_d = RWait;
      RWait: begin
        rvalid_d  = 1'b1;
        rdata_d   = rok_q ? ram_dout : 32'h0;
        rresp_d   = rok_q ? RESP_OKAY : RESP_DECERR;
        r_state_d = RData;
      end
      RData: begin
        if (axi_rready) begin
          rvalid_d  = 1'b0;
          r_state_d = RIdle;
        end
      end
      default: r_state_d = RIdle;
    endcase
    arready_d = (r_state_d == RIdle);
  end

  // All-zero strobes and out-of-window accesses leave the RAM idle.
  assign ram_en   = w_exec ? (wok_q && (wstrb_q != 4'b0000))
                           : ((r_state_q == RExec) && rok_q);
  assign ram_we   = w_exec ? wstrb_q : 4'b0000;
  assign ram_addr = w_exec ? waddr_q : raddr_q;

  axi_lite_ram_slave_bram_bytewise #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (wdata_q),
    .dout (ram_dout)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state_q <= WIdle;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      waddr_q   <= '0;
      wok_q     <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      r_state_q <= RIdle;
      arready_q <= 1'b0;
      raddr_q   <= '0;
      rok_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      waddr_q   <= waddr_d;
      wok_q     <= wok_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      raddr_q   <= raddr_d;
      rok_q     <= rok_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign axi_arready = arready_q;
  assign axi_rvalid  = rvalid_q;
  assign axi_rdata   = rdata_q;
  assign axi_rresp   = rresp_q;
  assign axi_awready = awready_q;
  assign axi_wready  = wready_q;
  assign axi_bvalid  = bvalid_q;
  assign axi_bresp   = bresp_q;

endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// Self-checking bench for axi_lite_ram_slave: vector table, corner sequences, random vs model.
module tb_axi_lite_ram_slave;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          DL2  = 12;
  localparam logic [31:0] WIN  = 32'd4 << DL2;

  logic        clk, rstn;
  logic [31:0] axi_araddr, axi_rdata, axi_awaddr, axi_wdata;
  logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
  logic [2:0]  axi_arprot, axi_awprot;
  logic [1:0]  axi_rresp, axi_bresp;
  logic [3:0]  axi_wstrb;

  axi_lite_ram_slave #(.BASE_ADDR(BASE), .DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rstn(rstn),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arprot(axi_arprot),
    .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awprot(axi_awprot),
    .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_bresp(axi_bresp),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference memory: byte contents plus which bytes have ever been written.
  logic [31:0] m_data  [int];
  logic [3:0]  m_known [int];

  function automatic bit m_in(input logic [31:0] a);
    return (a - BASE) < WIN;
  endfunction

  function automatic void m_write(input logic [31:0] a, input logic [31:0] d,
                                  input logic [3:0] s);
    int idx;
    if (!m_in(a)) return;
    idx = int'((a - BASE) / 4);
    if (!m_data.exists(idx)) begin
      m_data[idx]  = 32'h0;
      m_known[idx] = 4'h0;
    end
    for (int i = 0; i < 4; i++) begin
      if (s[i]) begin
        m_data[idx][8*i +: 8] = d[8*i +: 8];
        m_known[idx][i] = 1'b1;
      end
    end
  endfunction

  // Returns 0 when the expected data is not fully defined.
  function automatic bit m_read(input logic [31:0] a, output logic [1:0] resp,
                                output logic [31:0] d);
    int idx;
    resp = 2'b11;
    d    = 32'h0;
    if (!m_in(a)) return 1'b1;
    idx  = int'((a - BASE) / 4);
    resp = 2'b00;
    if (!m_data.exists(idx) || m_known[idx] != 4'hF) return 1'b0;
    d = m_data[idx];
    return 1'b1;
  endfunction

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output logic [1:0] resp, output int lat);
    int c;
    bit aw_done, w_done, aw_hs, w_hs, w_hold_ok, b_hold_ok;
    c = 0; aw_done = 0; w_done = 0; w_hold_ok = 1; b_hold_ok = 1; lat = 0; resp = 2'bxx;
    axi_awaddr = a; axi_wdata = d; axi_wstrb = s;
    while (!(aw_done && w_done)) begin
      axi_awvalid = !aw_done && (c >= aw_dly);
      axi_wvalid  = !w_done && (c >= w_dly);
      aw_hs = axi_awvalid && axi_awready;
      w_hs  = axi_wvalid && axi_wready;
      if ((w_done && axi_wready) || (aw_done && axi_awready)) w_hold_ok = 0;
      step();
      c++;
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      if (c > 60) begin
        axi_awvalid = 0; axi_wvalid = 0;
        check("aw_w_timeout", 32'(aw_done && w_done), 32'h1);
        return;
      end
    end
    axi_awvalid = 0;
    axi_wvalid  = 0;
    check("ready_hold", 32'(w_hold_ok), 32'h1);
    while (!axi_bvalid && lat < 20) begin
      step();
      lat++;
    end
    if (!axi_bvalid) begin
      check("bvalid_timeout", 32'(axi_bvalid), 32'h1);
      return;
    end
    repeat (b_dly) begin
      step();
      if (!axi_bvalid || axi_awready || axi_wready) b_hold_ok = 0;
    end
    check("b_hold", 32'(b_hold_ok), 32'h1);
    resp = axi_bresp;
    axi_bready = 1;
    step();
    axi_bready = 0;
    check("b_done", {29'b0, axi_bvalid, axi_awready, axi_wready}, 32'h3);
  endtask

  task automatic axi_read(input logic [31:0] a, input int r_dly,
                          output logic [31:0] d, output logic [1:0] resp, output int lat);
    int c;
    bit hs, stable;
    logic [31:0] first;
    c = 0; lat = 0; stable = 1; d = 32'hx; resp = 2'bxx;
    axi_araddr  = a;
    axi_arvalid = 1;
    do begin
      hs = axi_arready;
      step();
      c++;
    end while (!hs && c < 60);
    axi_arvalid = 0;
    if (!hs) begin
      check("ar_timeout", 32'(hs), 32'h1);
      return;
    end
    while (!axi_rvalid && lat < 20) begin
      step();
      lat++;
    end
    if (!axi_rvalid) begin
      check("rvalid_timeout", 32'(axi_rvalid), 32'h1);
      return;
    end
    first = axi_rdata;
    repeat (r_dly) begin
      step();
      if (!axi_rvalid || axi_rdata !== first || axi_arready) stable = 0;
    end
    check("r_hold", 32'(stable), 32'h1);
    d    = axi_rdata;
    resp = axi_rresp;
    axi_rready = 1;
    step();
    axi_rready = 0;
    check("r_done", {30'b0, axi_rvalid, axi_arready}, 32'h1);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [31:0] d, ed, a;
    logic [1:0]  r, er;
    int          lat, wlat, n;
    logic [1:0]  r2;

    tbl[0]  = '{1'b1, 32'h10,        32'hDEADBEEF, 4'hF, 0, 0, 2'b00, 32'h0};
    tbl[1]  = '{1'b0, 32'h10,        32'h0,        4'h0, 0, 0, 2'b00, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 32'h20,        32'h11223344, 4'hF, 0, 0, 2'b00, 32'h0};
    tbl[3]  = '{1'b1, 32'h20,        32'hAABBCCDD, 4'h5, 1, 0, 2'b00, 32'h0};
    tbl[4]  = '{1'b0, 32'h20,        32'h0,        4'h0, 0, 0, 2'b00, 32'h11BB33DD};
    tbl[5]  = '{1'b1, 32'h00,        32'hCAFEF00D, 4'hF, 0, 2, 2'b00, 32'h0};
    tbl[6]  = '{1'b1, BASE + WIN,    32'h12345678, 4'hF, 0, 0, 2'b11, 32'h0};
    tbl[7]  = '{1'b0, BASE + WIN,    32'h0,        4'h0, 0, 0, 2'b11, 32'h0};
    tbl[8]  = '{1'b0, 32'h00,        32'h0,        4'h0, 0, 0, 2'b00, 32'hCAFEF00D};
    tbl[9]  = '{1'b1, 32'h13,        32'h01020304, 4'h0, 0, 0, 2'b00, 32'h0};
    tbl[10] = '{1'b0, 32'h12,        32'h0,        4'h0, 0, 0, 2'b00, 32'hDEADBEEF};
    tbl[11] = '{1'b1, 32'hFFFF_FFFC, 32'h77777777, 4'hF, 0, 0, 2'b11, 32'h0};
    tbl[12] = '{1'b1, WIN - 4,       32'h0BADCAFE, 4'hF, 0, 0, 2'b00, 32'h0};
    tbl[13] = '{1'b0, WIN - 1,       32'h0,        4'h0, 0, 0, 2'b00, 32'h0BADCAFE};

    rstn = 0;
    axi_araddr = 0; axi_arvalid = 0; axi_arprot = 0; axi_rready = 0;
    axi_awaddr = 0; axi_awvalid = 0; axi_awprot = 0; axi_wdata = 0; axi_wstrb = 0;
    axi_wvalid = 0; axi_bready = 0;

    #2;
    check("rst_flags", {27'b0, axi_arready, axi_awready, axi_wready, axi_rvalid, axi_bvalid},
          32'h0);
    check("rst_rdata", axi_rdata, 32'h0);
    check("rst_resp", {28'b0, axi_rresp, axi_bresp}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1;
    step();
    check("post_rst_ready", {29'b0, axi_arready, axi_awready, axi_wready}, 32'h7);

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].wr) begin
        axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].aw_dly, tbl[i].w_dly, 0,
                  r, lat);
        m_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
        check($sformatf("tbl%0d_bresp", i), 32'(r), 32'(tbl[i].resp));
        check($sformatf("tbl%0d_blat", i), lat, 1);
      end else begin
        axi_read(tbl[i].addr, 0, d, r, lat);
        check($sformatf("tbl%0d_rresp", i), 32'(r), 32'(tbl[i].resp));
        check($sformatf("tbl%0d_rdata", i), d, tbl[i].rdata);
        check($sformatf("tbl%0d_rlat", i), lat, 2);
      end
    end

    // W first, AW three cycles later, then B held off for 5 cycles.
    axi_write(32'h50, 32'h5A5A0001, 4'hF, 3, 0, 5, r, lat);
    m_write(32'h50, 32'h5A5A0001, 4'hF);
    check("split_bresp", 32'(r), 32'h0);
    check("split_blat", lat, 1);
    axi_read(32'h50, 0, d, r, lat);
    check("split_rdata", d, 32'h5A5A0001);

    // Read and write to the same word start together; read must see the new data.
    axi_write(32'h30, 32'h11111111, 4'hF, 0, 0, 0, r, lat);
    fork
      axi_write(32'h30, 32'h00000055, 4'hF, 0, 0, 0, r2, wlat);
      axi_read(32'h30, 4, d, r, lat);
    join
    m_write(32'h30, 32'h00000055, 4'hF);
    check("conflict_rdata", d, 32'h00000055);
    check("conflict_rlat", lat, 3);
    check("conflict_blat", wlat, 1);
    check("conflict_bresp", 32'(r2), 32'h0);

    // Asynchronous reset while read data is being presented.
    axi_write(32'h40, 32'h600DF00D, 4'hF, 0, 0, 0, r, lat);
    m_write(32'h40, 32'h600DF00D, 4'hF);
    axi_araddr = 32'h40;
    axi_arvalid = 1;
    step();
    axi_arvalid = 0;
    repeat (3) step();
    check("pre_rst_rvalid", 32'(axi_rvalid), 32'h1);
    #3 rstn = 0;
    #1;
    check("async_rst", {28'b0, axi_rvalid, axi_arready, axi_awready, axi_wready}, 32'h0);
    step();
    step();
    @(negedge clk) rstn = 1;
    step();
    check("rst2_ready", {29'b0, axi_arready, axi_awready, axi_wready}, 32'h7);
    axi_read(32'h40, 0, d, r, lat);
    check("rst2_rdata", d, 32'h600DF00D);
    axi_read(32'h20, 0, d, r, lat);
    check("rst2_rdata2", d, 32'h11BB33DD);

    // Random traffic against the reference model.
    n = 0;
    while (n < 250) begin
      logic [3:0] s;
      int         sel;
      sel = int'($urandom_range(0, 15));
      if (sel == 0) a = BASE + WIN + 4 * $urandom_range(0, 255);
      else if (sel == 1) a = 32'hFFFF_FFF0 + $urandom_range(0, 15);
      else a = BASE + 4 * $urandom_range(0, 31) + $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1 && m_read(a, er, ed)) begin
        axi_read(a, int'($urandom_range(0, 3)), d, r, lat);
        check("rnd_rresp", 32'(r), 32'(er));
        check("rnd_rdata", d, ed);
        check("rnd_rlat", lat, 2);
      end else begin
        d = $urandom;
        s = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
        axi_write(a, d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 2)), r, lat);
        check("rnd_bresp", 32'(r), m_in(a) ? 32'h0 : 32'h3);
        check("rnd_blat", lat, 1);
        m_write(a, d, s);
      end
      n++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
